// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the DLX pipeline.
// Owns the PC, issues instruction-memory requests, applies decode's
// redirect/stall/kill requests and halts after an unkilled TRAP reaches IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [0:31] NOP_INSTR   = 32'h0000_0015,
    parameter logic [5:0]  TRAP_OPCODE = 6'h11
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [0:31] imem_rdata,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        stall,
    input  logic        kill_next,
    output logic [0:31] id_instr,
    output logic [31:0] id_pc_plus_four,
    output logic        id_should_be_killed,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [0:31] instr_q, instr_d;
    logic [31:0] ppf_q, ppf_d;
    logic        killed_q, killed_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus_four;
    logic        trap_in_id;

    assign pc_plus_four = pc_q + 32'd4;

    // The halt decision looks at the word already sitting in IF/ID, so a
    // TRAP takes effect one edge after it was loaded.
    assign trap_in_id = (instr_q[0:5] == TRAP_OPCODE) && !killed_q && valid_q;

    // Next-state, PC and IF/ID load selection; first matching RUN rule wins.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ppf_d    = ppf_q;
        killed_d = killed_q;
        valid_d  = valid_q;
        count_d  = count_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (trap_in_id) begin
                    state_d  = S_HALT;
                    instr_d  = NOP_INSTR;
                    killed_d = 1'b1;
                    valid_d  = 1'b0;
                end else if (branch || stall) begin
                    // Redirect and stall both squash the word being fetched;
                    // only a redirect moves the PC, a stall re-fetches it.
                    if (branch) begin
                        pc_d = branch_target;
                    end
                    instr_d  = imem_ready ? imem_rdata : NOP_INSTR;
                    ppf_d    = pc_plus_four;
                    killed_d = 1'b1;
                    valid_d  = imem_ready;
                end else if (!imem_ready) begin
                    instr_d  = NOP_INSTR;
                    killed_d = 1'b1;
                    valid_d  = 1'b0;
                end else begin
                    pc_d     = pc_plus_four;
                    instr_d  = imem_rdata;
                    ppf_d    = pc_plus_four;
                    killed_d = kill_next;
                    valid_d  = 1'b1;
                    if (!kill_next) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            S_HALT: begin
                instr_d  = NOP_INSTR;
                killed_d = 1'b1;
                valid_d  = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            ppf_q    <= RESET_PC + 32'd4;
            killed_q <= 1'b1;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ppf_q    <= ppf_d;
            killed_q <= killed_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign imem_req            = (state_q == S_RUN);
    assign imem_addr           = pc_q;
    assign halted              = (state_q == S_HALT);
    assign id_instr            = instr_q;
    assign id_pc_plus_four     = ppf_q;
    assign id_should_be_killed = killed_q;
    assign id_valid            = valid_q;
    assign fetch_count         = count_q;

endmodule
